// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared control-unit types and default sizes
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_ADDR  = 2'd1,
        FETCH_READ  = 2'd2,
        FETCH_LATCH = 2'd3
    } fetch_state_t;

    localparam int DEFAULT_ADDR_WIDTH  = 9;
    localparam int DEFAULT_MEM_TIMEOUT = 16;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: PC -> MAR -> memory read -> MDR -> IR
module fetch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] pc_value,
    output logic                  pc_inc,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  ir_valid,
    output logic                  done,
    output logic                  busy,
    output logic                  fault
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0] mdr;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  timeout_hit;
    logic                  unused_pc_bits;

    // Only the low address bits of the PC reach memory; the rest wrap away.
    assign unused_pc_bits = ^pc_value[DATA_WIDTH-1:ADDR_WIDTH];

    assign pc_inc      = (state == FETCH_ADDR);
    assign mem_read    = (state == FETCH_READ);
    assign mem_addr    = mar;
    assign busy        = (state != FETCH_IDLE);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE: begin
                if (start) state_next = FETCH_ADDR;
            end
            FETCH_ADDR: begin
                state_next = flush ? FETCH_IDLE : FETCH_READ;
            end
            FETCH_READ: begin
                if (flush || (!mem_ready && timeout_hit)) state_next = FETCH_IDLE;
                else if (mem_ready)                       state_next = FETCH_LATCH;
            end
            FETCH_LATCH: begin
                state_next = FETCH_IDLE;
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= FETCH_IDLE;
            mar      <= '0;
            mdr      <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            // flush suppresses every datapath update and invalidates ir
            if (busy && flush) begin
                ir_valid <= 1'b0;
            end else begin
                case (state)
                    FETCH_IDLE: begin
                        if (start) begin
                            fault    <= 1'b0;
                            ir_valid <= 1'b0;
                        end
                    end
                    FETCH_ADDR: begin
                        mar      <= pc_value[ADDR_WIDTH-1:0];
                        wait_cnt <= '0;
                    end
                    FETCH_READ: begin
                        if (mem_ready) begin
                            mdr <= mem_data;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                            if (timeout_hit) fault <= 1'b1;
                        end
                    end
                    FETCH_LATCH: begin
                        ir       <= mdr;
                        ir_valid <= 1'b1;
                        done     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch sequencer sitting directly downstream of the PC register: consumes the PC value, drives the PC increment strobe, runs the memory read handshake and loads the instruction register.
- Started by the control unit once per instruction.
- Reports completion, flush abort, or memory timeout fault back to control.

Parameters:
- DATA_WIDTH, 32, instruction/data word width.
- ADDR_WIDTH, 9, memory word-address width; low bits of PC used.
- MEM_TIMEOUT, 16, max READ cycles without mem_ready before fault; 0 disables timeout.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- clear  in  1  synchronous active-high reset.
- start  in  1  fetch request from control unit; sampled only in IDLE.
- flush  in  1  abort in-flight fetch (branch/exception).
- pc_value  in  DATA_WIDTH  current PC register output.
- pc_inc  out  1  increment strobe to PC register.
- mem_addr  out  ADDR_WIDTH  memory word address (MAR contents).
- mem_read  out  1  memory read request.
- mem_ready  in  1  memory read data valid this cycle.
- mem_data  in  DATA_WIDTH  memory read data.
- ir  out  DATA_WIDTH  instruction register.
- ir_valid  out  1  ir holds a completed fetch.
- done  out  1  one-cycle fetch-complete pulse.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  sticky memory-timeout flag.

Behaviour:
- Reset: clear=1 at a rising edge sets state=IDLE. It also zeroes mar, mdr, ir, ir_valid, done, fault and wait_cnt. clear has priority over every other input, including mid-fetch.
- Combinational outputs: pc_inc=1 only in ADDR. mem_read=1 only in READ. mem_addr=mar always. busy=(state!=IDLE).
- IDLE:
  - start=1 goes to ADDR, clears fault, clears ir_valid.
  - start is ignored while busy; there is no queuing.
- ADDR (T0):
  - mar <= pc_value[ADDR_WIDTH-1:0]; wait_cnt <= 0; next state READ.
  - The PC increments on the same edge, so mar captures the pre-increment address.
- READ (T1):
  - mem_ready=1: mdr <= mem_data; next LATCH.
  - Otherwise wait_cnt increments. If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT-1, then fault <= 1 and next IDLE, with no done and no ir update.
  - mem_ready outside READ is ignored.
- LATCH (T2): ir <= mdr; ir_valid <= 1; done <= 1 (registered, high exactly the following cycle); next IDLE.
- done: deasserted one cycle after assertion. A start in that cycle is accepted (state is IDLE).
- flush:
  - In ADDR, READ or LATCH, flush=1 sends the next state to IDLE. No mar/mdr/ir update occurs that edge, and ir_valid <= 0, done stays 0.
  - flush beats mem_ready and timeout on the same edge.
  - flush in IDLE has no effect and does not block a simultaneous start.
  - The PC increment already issued is not undone; control reloads the PC.
- Latency: with mem_ready high in the first READ cycle, the start edge E0 leads to ir/ir_valid/done visible after E3. Each READ wait cycle adds 1.
- Widths: wait_cnt is sized to hold MEM_TIMEOUT-1 (minimum 1 bit). pc_value upper bits above ADDR_WIDTH are ignored, so the address wraps modulo 2^ADDR_WIDTH.
- ir holds its last value until the next successful LATCH or clear.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding constants FETCH_IDLE=0, FETCH_ADDR=1, FETCH_READ=2, FETCH_LATCH=3 (2-bit);
  - default ADDR_WIDTH=9;
  - default MEM_TIMEOUT=16.
- No sub-module. The wait counter and MAR/MDR/IR registers are inline; one state register with a next-state block.

Test Plan:
- Basic fetch:
  - Stimulus: pc_value=0x00000005, start pulse, mem_ready=1 first READ cycle, mem_data=0x12345678.
  - Response: pc_inc high 1 cycle; mem_addr=5; ir=0x12345678, ir_valid=1, done 1-cycle pulse 3 cycles after start edge.
- Wait states:
  - Stimulus: mem_ready held low 4 READ cycles, then high with 0xDEADBEEF.
  - Response: mem_read high 5 cycles; done 7 cycles after start; fault=0; ir=0xDEADBEEF.
- Timeout:
  - Stimulus: MEM_TIMEOUT=16, mem_ready never high.
  - Response: fault=1 after 16th READ cycle; state IDLE; done never asserts; ir unchanged.
  - Follow-up: next start clears fault.
- Flush and reset:
  - Stimulus: flush=1 and mem_ready=1 on the same READ cycle.
  - Response: IDLE next, ir unchanged, ir_valid=0, no done.
  - Stimulus: clear=1 mid-READ. Response: all outputs zero next cycle.
- Ignored/back-to-back starts:
  - Stimulus: start held high continuously.
  - Response: fetches back-to-back, one pc_inc per fetch, no extra pc_inc while busy.
  - Stimulus: pc_value=0x00000205. Response: mem_addr=0x005 (wrap).
